// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, frame constants and the
// bit-period helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both flops
// reset to 1 so a reset never looks like a falling edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, with ack handshake, overrun and framing flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);
    localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);

    rx_state_t   state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= 16'd0;
            bit_cnt     <= 3'd0;
            data        <= 8'd0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            // A capture later in this block overrides the ack clear.
            if (data_ack && data_valid)
                data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= 16'd0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= 16'd0;
                        bit_cnt <= 3'd0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt        <= 16'd0;
                        shift[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= 16'd0;
                        if ((^shift) != rx_s)
                            parity_err <= 1'b1;
                        state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= 16'd0;
                        if (rx_s) begin
                            data       <= shift;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack)
                                overrun <= 1'b1;
                            state <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= RECOVER;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RECOVER: begin
                    // Hold off until the line returns high so a break cannot start a frame.
                    clk_cnt <= 16'd0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    clk_cnt <= 16'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit; expected bytes are
// queued by the stimulus and checked by an independent capture monitor.
module tb_uart_rx;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       framing_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    int         cyc = 0;
    int         start_cyc = 0;
    int         cap_cyc = 0;
    int         checks = 0;
    int         fails = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_dv = 1'b0;
    logic [7:0] prev_data = 8'd0;

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data        (data),
        .data_valid  (data_valid),
        .data_ack    (data_ack),
        .framing_err (framing_err),
        .overrun     (overrun),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every new byte presented (valid rise or data replaced) pops the scoreboard.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (framing_err === 1'b1) fe_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
        if (rst_n === 1'b1 && data_valid === 1'b1 && (!prev_dv || data !== prev_data)) begin
            cap_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL capture_unexpected: actual %02h required no byte", data);
            end else begin
                exp_b = exp_q.pop_front();
                if (data !== exp_b) begin
                    fails++;
                    $display("FAIL capture_data: actual %02h required %02h", data, exp_b);
                end
            end
        end
        prev_dv   = (data_valid === 1'b1);
        prev_data = data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Called at #1 after a posedge; leaves rx at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_bit();
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        wait_bit();
    endtask

    task automatic do_ack(input string name);
        data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
        chk(name, data_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe0;
        rx = 1'b1;
        data_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_data", data, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_framing", framing_err, 1'b0);
        chk("rst_parity", parity_err, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // 1: single byte, latency and ack
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        chk("t1_latency", cap_cyc - start_cyc, LAT);
        chk("t1_valid", data_valid, 1'b1);
        repeat (3) @(posedge clk);
        #1 do_ack("t1_ack_clears");
        chk("t1_framing", fe_cnt, 0);
        chk("t1_overrun", overrun, 1'b0);

        // 2: start glitch
        repeat (5) @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        @(posedge clk);
        #1 chk("t2_busy_start", busy, 1'b1);
        repeat (10) @(posedge clk);
        #1 chk("t2_busy_idle", busy, 1'b0);
        chk("t2_valid", data_valid, 1'b0);
        chk("t2_framing", fe_cnt, 0);

        // 3: framing error, line held low, then recovery
        send_frame(8'h3C, ^8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1 chk("t3_recover_busy", busy, 1'b1);
        chk("t3_framing_pulses", fe_cnt, 1);
        chk("t3_valid", data_valid, 1'b0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("t3_idle", busy, 1'b0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, ^8'h55, 1'b1);
        chk("t3_valid_55", data_valid, 1'b1);
        do_ack("t3_ack");

        // 4: back-to-back without ack -> overrun
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        send_frame(8'h01, ^8'h01, 1'b1);
        send_frame(8'hFE, ^8'hFE, 1'b1);
        chk("t4_data", data, 8'hFE);
        chk("t4_valid", data_valid, 1'b1);
        chk("t4_overrun", overrun, 1'b1);
        do_ack("t4_ack");
        repeat (5) @(posedge clk);
        #1 chk("t4_overrun_sticky", overrun, 1'b1);
        pulse_reset();
        chk("t4_overrun_reset", overrun, 1'b0);

        // 5: ack lands exactly on the capture edge of the second byte
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, ^8'h11, 1'b1);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, ^8'h22, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 data_ack = 1'b1;
                @(posedge clk);
                #1 data_ack = 1'b0;
            end
        join
        chk("t5_data", data, 8'h22);
        chk("t5_valid", data_valid, 1'b1);
        chk("t5_overrun", overrun, 1'b0);
        do_ack("t5_ack");

        // 6: parity
        pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        chk("t6_parity_ok", pe_cnt, pe0);
        do_ack("t6_ack_a");
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        chk("t6_parity_bad", pe_cnt, pe0 + 1);
        chk("t6_valid", data_valid, 1'b1);
        do_ack("t6_ack_b");
`else
        chk("t6_parity_tied", pe_cnt, 0);
`endif

        // reset during data bit 4, then a clean frame
        repeat (3) @(posedge clk);
        #1 rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            wait_bit();
        end
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx = 1'b1;
        chk("t7_busy", busy, 1'b0);
        chk("t7_valid", data_valid, 1'b0);
        chk("t7_data", data, 8'h00);
        chk("t7_framing", framing_err, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, ^8'hC3, 1'b1);
        chk("t7_valid_c3", data_valid, 1'b1);
        do_ack("t7_ack");

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver, 8N1, LSB first. Counterpart to the existing uart_tx.
- Receives image/weight/command bytes from the host PC and hands them to the loader and inference control logic.
- Each byte is held until the consumer acknowledges it; overrun and framing errors are flagged.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits per second.
- Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, 868 at defaults).
- Derived localparam HALF_BIT = CLKS_PER_BIT / 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous UART line; idles high.
- data  out  8  last received byte; stable while data_valid=1.
- data_valid  out  1  high from byte capture until data_ack.
- data_ack  in  1  consumer acknowledges data; clears data_valid next cycle.
- framing_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  sticky; set when a byte completes while data_valid=1; cleared only by reset.
- parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): synchronizer flops = 1, state = IDLE, counters = 0, data = 0, data_valid = 0, framing_err = 0, overrun = 0, parity_err = 0, busy = 0.
- Reset mid-frame aborts the frame silently; the partial byte is lost and no flags are raised.
- Synchronizer: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
- Bit-period counter clk_cnt is 16 bits and resets to 0 on every state transition.
- IDLE:
  - rx_s=0 -> START, clk_cnt=0.
- START:
  - At clk_cnt==HALF_BIT-1, recheck rx_s.
  - rx_s=0 -> DATA, bit_cnt=0, clk_cnt=0.
  - rx_s=1 -> glitch; return to IDLE with no flag.
- DATA:
  - At clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_cnt].
  - After bit 7 -> PARITY if the macro is defined, else STOP.
  - Sample points are therefore mid-bit.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 -> capture: data<=shift, data_valid<=1, then IDLE.
  - If data_valid was already 1 at capture: overwrite data and set overrun.
  - rx_s=0 -> pulse framing_err, discard the byte (data and data_valid unchanged), go to RECOVER.
- RECOVER:
  - Wait for rx_s=1, then IDLE.
  - Prevents a break condition from retriggering START.
- Handshake:
  - data_ack while data_valid=1 clears data_valid on the next edge.
  - data_ack while data_valid=0 is ignored.
  - Capture and ack in the same cycle: capture wins; data_valid stays 1, data takes the new byte, overrun is not set.
- Latency: data_valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge, or +CLKS_PER_BIT with parity enabled.
- Back-to-back frames: a falling edge seen in the cycle after the STOP sample is accepted; no idle gap is required.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; PARITY state added between DATA and STOP.
  - Parity bit sampled mid-bit.
  - Mismatch with even parity (^shift != sampled bit): pulse parity_err; the byte is still delivered if the stop bit is good.
- Undefined:
  - Frame is 8N1; no PARITY state.
  - parity_err tied to 0.

Decomposition:
- Package uart_pkg holds:
  - FSM state encodings: IDLE, START, DATA, PARITY, STOP, RECOVER (3-bit).
  - Frame constants: DATA_BITS=8.
  - A function computing CLKS_PER_BIT, shared with uart_tx.
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value 1, reusable for other async inputs.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10):
1. Send byte 0xA5, 8N1, ack 5 cycles after data_valid -> data=0xA5, data_valid rises 2+5+90+1=98 cycles after the start edge, then falls the cycle after ack; no error flags.
2. Drive rx low for 3 cycles, then high -> START aborts, busy returns to 0, data_valid stays 0, no flags.
3. Send 0x3C with stop bit driven 0, rx then held low 40 cycles, then high -> one framing_err pulse, data_valid stays 0, FSM waits in RECOVER until rx high; a following 0x55 is received correctly.
4. Send 0x01 then 0xFE back-to-back without ack -> data=0xFE, data_valid=1, overrun=1 and stays set until rst_n=0.
5. Assert data_ack in the exact capture cycle of the second byte, with the first byte still unacked -> data=new byte, data_valid=1, overrun=0.
6. With UART_RX_PARITY_EN: send 0x07 with parity bit 1 (correct) and then 0x07 with parity bit 0 -> first delivered with no parity_err; second delivered with one parity_err pulse. Also assert rst_n=0 mid-data-bit 4 -> all outputs return to reset values, and the next frame is received cleanly.
